// File: rtl/read_data_channel.sv
// Read-data return path of the 2-master/2-slave AXI interconnect.
// Routes one slave burst at a time to the master encoded in the upper RID bits.
module read_data_channel #(
  parameter int DATA_W = 32,
  parameter int SID_W  = 8,
  parameter int MID_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,

  input  logic [SID_W-1:0]  RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,

  input  logic [SID_W-1:0]  RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,

  output logic [MID_W-1:0]  RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,

  output logic [MID_W-1:0]  RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1
);

  localparam int MIX_W = SID_W - MID_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_S0 = 2'd1,
    GNT_S1 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_M0   = 2'd0,
    TGT_M1   = 2'd1,
    TGT_SINK = 2'd2
  } tgt_t;

  state_t state_q, state_d;
  tgt_t   tgt_q, tgt_d;
  logic   last_grant_q, last_grant_d;

  logic [SID_W-1:0]  sel_rid_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [1:0]        sel_resp_s;
  logic              sel_last_s;
  logic              sel_valid_s;
  logic              sel_ready_s;
  logic              granted_s;

  // Master index lives above the master-side ID; anything but 0/1 is a decode error.
  function automatic tgt_t decode_tgt(input logic [SID_W-1:0] rid);
    logic [MIX_W-1:0] idx;
    idx = rid[SID_W-1:MID_W];
    if (idx == MIX_W'(0)) begin
      return TGT_M0;
    end else if (idx == MIX_W'(1)) begin
      return TGT_M1;
    end else begin
      return TGT_SINK;
    end
  endfunction

  // Mux the granted slave's beat and pick the ready source for the captured target.
  always_comb begin
    granted_s = (state_q == GNT_S0) || (state_q == GNT_S1);
    if (state_q == GNT_S1) begin
      sel_rid_s   = RID_S1;
      sel_data_s  = RDATA_S1;
      sel_resp_s  = RRESP_S1;
      sel_last_s  = RLAST_S1;
      sel_valid_s = RVALID_S1;
    end else begin
      sel_rid_s   = RID_S0;
      sel_data_s  = RDATA_S0;
      sel_resp_s  = RRESP_S0;
      sel_last_s  = RLAST_S0;
      sel_valid_s = RVALID_S0;
    end
    case (tgt_q)
      TGT_M0:   sel_ready_s = RREADY_M0;
      TGT_M1:   sel_ready_s = RREADY_M1;
      TGT_SINK: sel_ready_s = 1'b1;
      default:  sel_ready_s = 1'b0;
    endcase
  end

  // Slave-side ready: only the granted slave sees a ready, and only from registered state.
  always_comb begin
    RREADY_S0 = 1'b0;
    RREADY_S1 = 1'b0;
    case (state_q)
      GNT_S0:  RREADY_S0 = sel_ready_s;
      GNT_S1:  RREADY_S1 = sel_ready_s;
      IDLE:    RREADY_S0 = 1'b0;
      default: RREADY_S1 = 1'b0;
    endcase
  end

  // Master-side outputs: the targeted master gets the beat, the other sees all zeros.
  always_comb begin
    RID_M0    = {MID_W{1'b0}};
    RDATA_M0  = {DATA_W{1'b0}};
    RRESP_M0  = 2'b00;
    RLAST_M0  = 1'b0;
    RVALID_M0 = 1'b0;
    RID_M1    = {MID_W{1'b0}};
    RDATA_M1  = {DATA_W{1'b0}};
    RRESP_M1  = 2'b00;
    RLAST_M1  = 1'b0;
    RVALID_M1 = 1'b0;
    if (granted_s && (tgt_q == TGT_M0)) begin
      RID_M0    = sel_rid_s[MID_W-1:0];
      RDATA_M0  = sel_data_s;
      RRESP_M0  = sel_resp_s;
      RLAST_M0  = sel_last_s;
      RVALID_M0 = sel_valid_s;
    end else if (granted_s && (tgt_q == TGT_M1)) begin
      RID_M1    = sel_rid_s[MID_W-1:0];
      RDATA_M1  = sel_data_s;
      RRESP_M1  = sel_resp_s;
      RLAST_M1  = sel_last_s;
      RVALID_M1 = sel_valid_s;
    end else begin
      RVALID_M0 = 1'b0;
      RVALID_M1 = 1'b0;
    end
  end

  // Round-robin grant on ties; the grant is held until the RLAST handshake.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (RVALID_S0 && (!RVALID_S1 || last_grant_q)) begin
          state_d      = GNT_S0;
          last_grant_d = 1'b0;
          tgt_d        = decode_tgt(RID_S0);
        end else if (RVALID_S1) begin
          state_d      = GNT_S1;
          last_grant_d = 1'b1;
          tgt_d        = decode_tgt(RID_S1);
        end else begin
          state_d = IDLE;
        end
      end
      GNT_S0: begin
        if (RVALID_S0 && RREADY_S0 && RLAST_S0) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_S0;
        end
      end
      GNT_S1: begin
        if (RVALID_S1 && RREADY_S1 && RLAST_S1) begin
          state_d = IDLE;
        end else begin
          state_d = GNT_S1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset leaves last_grant at S1 so S0 wins the first tie.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_SINK;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
